// File: rtl/card_matcher_pkg.sv
// Shared types and constants for the card match-decision stage.
package card_matcher_pkg;

    localparam int CELLS   = 36;
    localparam int PAIRS   = 18;
    localparam int POS_W   = 6;
    localparam int PAIRS_W = 5;
    localparam int SCORE_W = 8;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } colour_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_INC = 8'd2;
    localparam logic [SCORE_W-1:0] SCORE_DEC = 8'd1;

    function automatic logic [SCORE_W-1:0] score_up(input logic [SCORE_W-1:0] s);
        return (s > (8'd255 - SCORE_INC)) ? 8'd255 : s + SCORE_INC;
    endfunction

    function automatic logic [SCORE_W-1:0] score_down(input logic [SCORE_W-1:0] s);
        return (s < SCORE_DEC) ? 8'd0 : s - SCORE_DEC;
    endfunction

endpackage

// File: rtl/card_matcher.sv
// Match-decision stage: reads two card colours from the board ROM and removes equal pairs.
// Optional scoring is enabled with the CARD_MATCHER_SCORE_EN macro.
module card_matcher #(
    parameter int CELLS = card_matcher_pkg::CELLS,
    parameter int PAIRS = card_matcher_pkg::PAIRS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               new_game,
    input  logic                               start,
    input  logic [card_matcher_pkg::POS_W-1:0] pos_a,
    input  logic [card_matcher_pkg::POS_W-1:0] pos_b,
    output logic [card_matcher_pkg::POS_W-1:0] board_addr,
    input  logic [2:0]                         board_r,
    input  logic [2:0]                         board_g,
    input  logic [1:0]                         board_b,
    output logic                               busy,
    output logic                               done,
    output logic                               match,
    output logic                               reject,
    output logic [CELLS-1:0]                   removed,
    output logic [card_matcher_pkg::PAIRS_W-1:0] pairs_left,
    output logic                               win,
    output logic [card_matcher_pkg::SCORE_W-1:0] score
);
    import card_matcher_pkg::*;

    localparam logic [POS_W-1:0]   CELLS_P = POS_W'(CELLS);
    localparam logic [PAIRS_W-1:0] PAIRS_P = PAIRS_W'(PAIRS);

    state_t               state_q, state_d;
    logic [POS_W-1:0]     board_addr_q, board_addr_d;
    logic [POS_W-1:0]     pos_a_q, pos_a_d;
    logic [POS_W-1:0]     pos_b_q, pos_b_d;
    colour_t              colour_a_q, colour_a_d;
    logic                 done_q, done_d;
    logic                 match_q, match_d;
    logic                 reject_q, reject_d;
    logic [CELLS-1:0]     removed_q, removed_d;
    logic [PAIRS_W-1:0]   pairs_left_q, pairs_left_d;
    logic                 win_q, win_d;

    colour_t              rom_colour;
    logic [2**POS_W-1:0]  removed_ext;
    logic                 illegal;

    assign rom_colour  = colour_t'({board_r, board_g, board_b});
    // Zero-extend so any 6-bit position indexes safely, including out-of-range ones.
    assign removed_ext = {{(2**POS_W - CELLS){1'b0}}, removed_q};
    assign illegal     = (pos_a >= CELLS_P) || (pos_b >= CELLS_P) || (pos_a == pos_b)
                       || removed_ext[pos_a] || removed_ext[pos_b] || win_q;

    always_comb begin
        state_d      = state_q;
        board_addr_d = board_addr_q;
        pos_a_d      = pos_a_q;
        pos_b_d      = pos_b_q;
        colour_a_d   = colour_a_q;
        done_d       = 1'b0;
        match_d      = match_q;
        reject_d     = reject_q;
        removed_d    = removed_q;
        pairs_left_d = pairs_left_q;
        win_d        = win_q;

        if (new_game) begin
            state_d      = IDLE;
            match_d      = 1'b0;
            reject_d     = 1'b0;
            removed_d    = '0;
            pairs_left_d = PAIRS_P;
            win_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            done_d   = 1'b1;
                            reject_d = 1'b1;
                            match_d  = 1'b0;
                        end else begin
                            pos_a_d      = pos_a;
                            pos_b_d      = pos_b;
                            board_addr_d = pos_a;
                            state_d      = RD_A;
                        end
                    end
                end
                RD_A: begin
                    board_addr_d = pos_b_q;
                    state_d      = RD_B;
                end
                RD_B: begin
                    colour_a_d = rom_colour;
                    state_d    = CMP;
                end
                CMP: begin
                    done_d   = 1'b1;
                    reject_d = 1'b0;
                    state_d  = IDLE;
                    if (colour_a_q == rom_colour) begin
                        match_d            = 1'b1;
                        removed_d[pos_a_q] = 1'b1;
                        removed_d[pos_b_q] = 1'b1;
                        pairs_left_d       = pairs_left_q - 5'd1;
                        if (pairs_left_q == 5'd1) begin
                            win_d = 1'b1;
                        end
                    end else begin
                        match_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            board_addr_q <= '0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            reject_q     <= 1'b0;
            removed_q    <= '0;
            pairs_left_q <= PAIRS_P;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_addr_q <= board_addr_d;
            done_q       <= done_d;
            match_q      <= match_d;
            reject_q     <= reject_d;
            removed_q    <= removed_d;
            pairs_left_q <= pairs_left_d;
            win_q        <= win_d;
        end
    end

    // Latched request and first colour need no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        pos_a_q    <= pos_a_d;
        pos_b_q    <= pos_b_d;
        colour_a_q <= colour_a_d;
    end

`ifdef CARD_MATCHER_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (new_game) begin
            score_d = '0;
        end else if (state_q == CMP) begin
            score_d = (colour_a_q == rom_colour) ? score_up(score_q) : score_down(score_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign board_addr = board_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign match      = match_q;
    assign reject     = reject_q;
    assign removed    = removed_q;
    assign pairs_left = pairs_left_q;
    assign win        = win_q;

endmodule
